// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stall/flush/forwarding control plus stall/flush event counters and a stall watchdog.
// Optional forwarding path is compiled in with macro HAZARD_FWD_EN.
module hazard_ctrl #(
  localparam int unsigned REG_W  = 5,
  localparam int unsigned CNT_W  = 16,
  localparam int unsigned CONS_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] D_rs,
  input  logic [REG_W-1:0] D_rt,
  input  logic             D_useRs,
  input  logic             D_useRt,
  input  logic [REG_W-1:0] X_dest,
  input  logic [REG_W-1:0] M_dest,
  input  logic [REG_W-1:0] W_dest,
  input  logic             X_RegWrite,
  input  logic             M_RegWrite,
  input  logic             W_RegWrite,
  input  logic             X_MemRead,
  input  logic [REG_W-1:0] X_rs,
  input  logic [REG_W-1:0] X_rt,
  input  logic             M_Branch,
  input  logic             M_Zero,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_src,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             hz_err
);

  typedef enum logic {RUN, STALL} state_t;

  state_t              state, next_state;
  logic                hit_x;
  logic                stall_req;
  logic                flush_req;
  logic                stall_apply;
  logic [CONS_W-1:0]   cons_cnt;

  assign hit_x = X_RegWrite && (X_dest != '0) &&
                 ((D_useRs && (D_rs == X_dest)) || (D_useRt && (D_rt == X_dest)));
  assign flush_req   = M_Branch && M_Zero;
  assign stall_apply = stall_req && !flush_req;

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time; everything else is bypassed.
  assign stall_req = hit_x && X_MemRead;

  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (M_RegWrite && (M_dest != '0) && (M_dest == X_rs))      fwdA = 2'b10;
    else if (W_RegWrite && (W_dest != '0) && (W_dest == X_rs)) fwdA = 2'b01;
    if (M_RegWrite && (M_dest != '0) && (M_dest == X_rt))      fwdB = 2'b10;
    else if (W_RegWrite && (W_dest != '0) && (W_dest == X_rt)) fwdB = 2'b01;
  end
`else
  logic hit_m;
  logic unused_fwd_inputs;

  // WB writes the regfile in the first half-cycle, so only EX and MEM producers stall.
  assign hit_m = M_RegWrite && (M_dest != '0) &&
                 ((D_useRs && (D_rs == M_dest)) || (D_useRt && (D_rt == M_dest)));
  assign stall_req = hit_x || hit_m;
  assign fwdA = 2'b00;
  assign fwdB = 2'b00;
  assign unused_fwd_inputs = ^{W_dest, W_RegWrite, X_rs, X_rt, X_MemRead};
`endif

  always_ff @(negedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  // Next state and pipeline control; flush always wins over stall.
  always_comb begin
    next_state  = state;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_src      = 1'b0;
    case (state)
      RUN:     if (stall_apply) next_state = STALL;
      STALL:   if (!stall_apply) next_state = RUN;
      default: next_state = RUN;
    endcase
    if (flush_req) begin
      next_state  = RUN;
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (stall_req) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      cons_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      hz_err    <= 1'b0;
    end else begin
      if (stall_apply) begin
        if (cons_cnt != '1) cons_cnt <= cons_cnt + CONS_W'(1);
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        // Fourth back-to-back stall edge trips the sticky watchdog.
        if (cons_cnt == CONS_W'(3)) hz_err <= 1'b1;
      end else begin
        cons_cnt <= '0;
      end
      if (flush_req && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a behavioural model; honours HAZARD_FWD_EN.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  D_rs, D_rt, X_dest, M_dest, W_dest, X_rs, X_rt;
  logic        D_useRs, D_useRt, X_RegWrite, M_RegWrite, W_RegWrite, X_MemRead;
  logic        M_Branch, M_Zero;
  logic        pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pc_src;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] stall_cnt, flush_cnt;
  logic        hz_err;

  int checks = 0;
  int errors = 0;
  int m_stall, m_flush, m_cons;
  bit m_hz;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .D_rs(D_rs), .D_rt(D_rt), .D_useRs(D_useRs), .D_useRt(D_useRt),
    .X_dest(X_dest), .M_dest(M_dest), .W_dest(W_dest),
    .X_RegWrite(X_RegWrite), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
    .X_MemRead(X_MemRead), .X_rs(X_rs), .X_rt(X_rt),
    .M_Branch(M_Branch), .M_Zero(M_Zero),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .pc_src(pc_src), .fwdA(fwdA), .fwdB(fwdB),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hz_err(hz_err)
  );

  // ---------------- reference model ----------------
  function automatic bit reads(input logic [4:0] dest, input logic we);
    if (!we || dest == 0) return 0;
    return (D_useRs && D_rs == dest) || (D_useRt && D_rt == dest);
  endfunction

  function automatic bit model_stall();
`ifdef HAZARD_FWD_EN
    return reads(X_dest, X_RegWrite) && X_MemRead;
`else
    return reads(X_dest, X_RegWrite) || reads(M_dest, M_RegWrite);
`endif
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
`ifdef HAZARD_FWD_EN
    if (src != 0 && M_RegWrite && M_dest == src) return 2'b10;
    if (src != 0 && W_RegWrite && W_dest == src) return 2'b01;
`endif
    return 2'b00;
  endfunction

  // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pc_src, fwdA, fwdB}
  function automatic logic [10:0] model_ctrl();
    logic [3:0] f;
    f = {model_fwd(X_rs), model_fwd(X_rt)};
    if (M_Branch && M_Zero) return {7'b1101111, f};
    if (model_stall())      return {7'b0010000, f};
    return {7'b1100000, f};
  endfunction

  function automatic logic [10:0] dut_ctrl();
    return {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pc_src, fwdA, fwdB};
  endfunction

  task automatic model_clear();
    m_stall = 0; m_flush = 0; m_cons = 0; m_hz = 0;
  endtask

  task automatic model_edge();
    bit fl, st;
    if (rst) return;
    fl = M_Branch && M_Zero;
    st = model_stall() && !fl;
    if (fl && m_flush < 65535) m_flush++;
    if (st) begin
      if (m_stall < 65535) m_stall++;
      if (m_cons + 1 == 4) m_hz = 1;
      if (m_cons < 7) m_cons++;
    end else m_cons = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    {D_rs, D_rt, X_dest, M_dest, W_dest, X_rs, X_rt} = '0;
    {D_useRs, D_useRt, X_RegWrite, M_RegWrite, W_RegWrite, X_MemRead, M_Branch, M_Zero} = '0;
  endtask

  task automatic load_use_inputs();
    idle_inputs();
    X_MemRead = 1; X_RegWrite = 1; X_dest = 5'd8; D_rs = 5'd8; D_useRs = 1;
  endtask

  task automatic cycle();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1;
    model_clear();
    #2;
    rst = 0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    model_clear();
    #1;
    checks++;
    if ({stall_cnt, flush_cnt, hz_err} !== 33'd0) begin
      errors++; $display("FAIL reset_counters: got %h/%h/%b want 0/0/0", stall_cnt, flush_cnt, hz_err);
    end
    checks++;
    if (dut_ctrl() !== 11'b11000000000) begin
      errors++; $display("FAIL reset_ctrl: got %b want %b", dut_ctrl(), 11'b11000000000);
    end
    load_use_inputs();
    #1;
    checks++;
    if (dut_ctrl() !== model_ctrl()) begin
      errors++; $display("FAIL reset_comb_live: got %b want %b", dut_ctrl(), model_ctrl());
    end
    @(negedge clk); #1;
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_hold: stall_cnt got %h want 0000", stall_cnt);
    end
    idle_inputs();
    rst = 0;
    cycle();
  endtask

  task automatic test_load_use();
    pulse_reset();
    load_use_inputs();
    #1;
    checks++;
    if (dut_ctrl() !== 11'b00100000000) begin
      errors++; $display("FAIL load_use_ctrl: got %b want %b", dut_ctrl(), 11'b00100000000);
    end
    cycle();
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++; $display("FAIL load_use_cnt: got %h want 0001", stall_cnt);
    end
    idle_inputs();
    #1;
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++; $display("FAIL load_use_release: pc_write %b bubble %b want 1 0", pc_write, idex_bubble);
    end
    cycle();
  endtask

  task automatic test_forwarding();
    logic [1:0] e1, e2;
`ifdef HAZARD_FWD_EN
    e1 = 2'b10; e2 = 2'b01;
`else
    e1 = 2'b00; e2 = 2'b00;
`endif
    idle_inputs();
    M_dest = 9; M_RegWrite = 1; W_dest = 9; W_RegWrite = 1; X_rs = 9; X_rt = 9;
    #1;
    checks++;
    if (fwdA !== e1 || fwdB !== e1) begin
      errors++; $display("FAIL fwd_mem: got %b/%b want %b", fwdA, fwdB, e1);
    end
    M_RegWrite = 0;
    #1;
    checks++;
    if (fwdA !== e2 || fwdB !== e2) begin
      errors++; $display("FAIL fwd_wb: got %b/%b want %b", fwdA, fwdB, e2);
    end
    M_dest = 0; W_dest = 0; M_RegWrite = 1; X_rs = 0; X_rt = 0;
    #1;
    checks++;
    if (fwdA !== 2'b00 || fwdB !== 2'b00) begin
      errors++; $display("FAIL fwd_r0: got %b/%b want 00", fwdA, fwdB);
    end
    idle_inputs();
  endtask

  task automatic test_alu_raw();
    int exp_cnt;
`ifdef HAZARD_FWD_EN
    exp_cnt = 0;
`else
    exp_cnt = 2;
`endif
    pulse_reset();
    idle_inputs();
    X_dest = 5; X_RegWrite = 1; D_rt = 5; D_useRt = 1;
    #1;
    checks++;
    if (dut_ctrl() !== model_ctrl()) begin
      errors++; $display("FAIL raw_ex: got %b want %b", dut_ctrl(), model_ctrl());
    end
    cycle();
    X_dest = 0; X_RegWrite = 0; M_dest = 5; M_RegWrite = 1;
    #1;
    checks++;
    if (dut_ctrl() !== model_ctrl()) begin
      errors++; $display("FAIL raw_mem: got %b want %b", dut_ctrl(), model_ctrl());
    end
    cycle();
    M_dest = 0; M_RegWrite = 0; W_dest = 5; W_RegWrite = 1;
    #1;
    checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
      errors++; $display("FAIL raw_wb_release: pc_write %b bubble %b want 1 0", pc_write, idex_bubble);
    end
    cycle();
    checks++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL raw_cnt: got %0d want %0d", stall_cnt, exp_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_branch_during_stall();
    pulse_reset();
    load_use_inputs();
    cycle();
    M_Branch = 1; M_Zero = 1;
    #1;
    checks++;
    if (dut_ctrl() !== 11'b11011110000) begin
      errors++; $display("FAIL branch_ctrl: got %b want %b", dut_ctrl(), 11'b11011110000);
    end
    cycle();
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL branch_cnt: flush %0d stall %0d want 1 1", flush_cnt, stall_cnt);
    end
    // Three more stalls after the flush must not trip the watchdog: the run restarted.
    M_Branch = 0; M_Zero = 0;
    repeat (3) cycle();
    checks++;
    if (hz_err !== 1'b0 || stall_cnt !== 16'd4) begin
      errors++; $display("FAIL branch_run_restart: hz %b stall %0d want 0 4", hz_err, stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    pulse_reset();
    load_use_inputs();
    repeat (3) cycle();
    checks++;
    if (hz_err !== 1'b0) begin
      errors++; $display("FAIL wdog_early: got %b want 0", hz_err);
    end
    cycle();
    checks++;
    if (hz_err !== 1'b1) begin
      errors++; $display("FAIL wdog_trip: got %b want 1", hz_err);
    end
    idle_inputs();
    cycle();
    checks++;
    if (hz_err !== 1'b1) begin
      errors++; $display("FAIL wdog_sticky: got %b want 1", hz_err);
    end
    pulse_reset();
    checks++;
    if (hz_err !== 1'b0) begin
      errors++; $display("FAIL wdog_reset: got %b want 0", hz_err);
    end
  endtask

  task automatic test_random();
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      D_rs = 5'($urandom_range(0, 3)); D_rt = 5'($urandom_range(0, 3));
      X_dest = 5'($urandom_range(0, 3)); M_dest = 5'($urandom_range(0, 3));
      W_dest = 5'($urandom_range(0, 3));
      X_rs = 5'($urandom_range(0, 3)); X_rt = 5'($urandom_range(0, 3));
      {D_useRs, D_useRt, X_RegWrite, M_RegWrite, W_RegWrite, X_MemRead} = 6'($urandom);
      M_Branch = ($urandom_range(0, 5) == 0);
      M_Zero = M_Branch ? 1'($urandom) : 1'b0;
      #1;
      checks++;
      if (dut_ctrl() !== model_ctrl()) begin
        errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, dut_ctrl(), model_ctrl());
      end
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset();
        checks++;
        if ({stall_cnt, flush_cnt, hz_err} !== 33'd0) begin
          errors++; $display("FAIL rand_async_rst[%0d]: got %h/%h/%b want 0", i, stall_cnt, flush_cnt, hz_err);
        end
      end
      cycle();
      checks++;
      if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) || hz_err !== m_hz) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d/%b want %0d/%0d/%b",
                 i, stall_cnt, flush_cnt, hz_err, m_stall, m_flush, m_hz);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    pulse_reset();
    load_use_inputs();
    repeat (65534) cycle();
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++; $display("FAIL sat_preload: got %h want fffe", stall_cnt);
    end
    repeat (3) cycle();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold: got %h want ffff", stall_cnt);
    end
    idle_inputs();
    M_Branch = 1; M_Zero = 1;
    cycle();
    idle_inputs();
    #1;
    rst = 1;
    model_clear();
    #1;
    checks++;
    if ({stall_cnt, flush_cnt, hz_err} !== 33'd0) begin
      errors++; $display("FAIL sat_async_rst: got %h/%h/%b want 0", stall_cnt, flush_cnt, hz_err);
    end
    rst = 0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_alu_raw();
    test_branch_during_stall();
    test_watchdog();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; all state updates on falling edge, matching the pipeline registers.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: D_rs, D_rt  in  5 each  ID-stage source registers; D_useRs, D_useRt  in  1 each  source actually read.
REQ-004 SHALL have: X_dest, M_dest, W_dest  in  5 each  destination register of the EX, MEM and WB stages (post-RegDst mux).
REQ-005 SHALL have: X_RegWrite, M_RegWrite, W_RegWrite, X_MemRead  in  1 each  stage control bits.
REQ-006 SHALL have: X_rs, X_rt  in  5 each  EX-stage operand registers (forwarding compare).
REQ-007 SHALL have: M_Branch, M_Zero  in  1 each  branch resolved in MEM.
REQ-008 SHALL have: pc_write, ifid_write  out  1 each  low = hold PC and IF/ID.
REQ-009 SHALL have: idex_bubble  out  1  high = ID/EX loads all-zero controls; ifid_flush, idex_flush, exmem_flush  out  1 each; pc_src  out  1  select branch target.
REQ-010 SHALL have: fwdA, fwdB  out  2 each  00 regfile, 10 from MEM, 01 from WB.
REQ-011 SHALL have: stall_cnt, flush_cnt  out  16 each  event counters; hz_err  out  1  sticky watchdog flag.

Function
REQ-012 SHALL define hitX = X_RegWrite & (X_dest!=0) & ((D_useRs & D_rs==X_dest) | (D_useRt & D_rt==X_dest)); hitM identical using M_*.
REQ-013 SHALL define flush_req = M_Branch & M_Zero.
REQ-014 SHALL define stall_req = hitX & X_MemRead with FWD_EN, hitX | hitM without.
REQ-015 SHALL, when flush_req, drive pc_src=1, ifid_flush=idex_flush=exmem_flush=1, pc_write=1, ifid_write=1, idex_bubble=0 combinationally in the same cycle; flush overrides stall.
REQ-016 SHALL, when stall_req & !flush_req, drive pc_write=0, ifid_write=0, idex_bubble=1, all flushes 0.
REQ-017 SHALL otherwise drive pc_write=1, ifid_write=1, all other control outputs 0.
REQ-018 SHALL hold a 2-state FSM RUN/STALL: RUN->STALL on stall_req & !flush_req; STALL->STALL while that persists; STALL->RUN otherwise; flush_req from any state -> RUN.
REQ-019 SHALL keep a 3-bit consecutive-stall counter: +1 per falling edge in which stall is applied (saturate at 7), cleared on any non-stall edge.
REQ-020 SHALL set hz_err on the edge where the consecutive counter would reach 4 (4th consecutive stall cycle); hz_err stays 1 until rst.
REQ-021 SHALL increment stall_cnt per stall edge and flush_cnt per flush edge, each saturating at 0xFFFF (no wrap).
REQ-022 SHALL treat register 0 as never hazarding and never forwarding.

Reset
REQ-023 SHALL on rst=1, asynchronously: FSM=RUN, consecutive counter=0, stall_cnt=0, flush_cnt=0, hz_err=0.
REQ-024 SHALL keep combinational outputs input-driven during reset; counters hold 0 and FSM holds RUN until rst falls.
REQ-025 SHALL, on reset asserted mid-stall, clear state immediately; the first falling edge after release evaluates with fresh state.

Configuration
REQ-026 SHALL compile forwarding in only when macro HAZARD_FWD_EN is defined.
REQ-027 SHALL with HAZARD_FWD_EN: fwdA=10 if M_RegWrite & M_dest!=0 & M_dest==X_rs, else 01 if W_RegWrite & W_dest!=0 & W_dest==X_rs, else 00; fwdB same with X_rt; MEM wins over WB.
REQ-028 SHALL without HAZARD_FWD_EN: fwdA=fwdB=00 constant; stall per REQ-014 non-forwarding rule (regfile writes first half, reads second half, so WB never stalls).

Verification
REQ-029 SHALL cover load-use: X_MemRead=1, X_RegWrite=1, X_dest=8, D_rs=8, D_useRs=1 -> pc_write=0, idex_bubble=1 for one cycle, stall_cnt 0->1 (both builds).
REQ-030 SHALL cover forwarding (FWD_EN): M_dest=9, M_RegWrite=1, W_dest=9, W_RegWrite=1, X_rs=9 -> fwdA=10; M_RegWrite=0 -> fwdA=01; X_rs=0 with dest 0 -> 00.
REQ-031 SHALL cover non-FWD ALU RAW: X_dest=5 RegWrite, D_rt=5 useRt -> 2 stall cycles as instruction moves EX->MEM, then release; stall_cnt=2.
REQ-032 SHALL cover branch during stall: stall_req=1 and M_Branch=M_Zero=1 same cycle -> all three flushes=1, pc_src=1, pc_write=1, idex_bubble=0, flush_cnt+1, stall_cnt unchanged, FSM=RUN.
REQ-033 SHALL cover watchdog: force stall_req 4 consecutive cycles -> hz_err=1 after 4th edge, stays 1 after stall drops; rst -> 0.
REQ-034 SHALL cover saturation and async reset: preload stall_cnt to 0xFFFE, 3 stalls -> 0xFFFF; rst pulse between edges -> all counters 0 immediately.
